// File: rtl/sequence_detector.sv
// sequence_detector
//   Moore FSM that raises Y for one cycle when the last four sampled bits of
//   the serial input X are 1,0,0,1 (oldest first).
//
//   Ports:
//     Clk    in   system clock, all state updates on the rising edge
//     Reset  in   synchronous active-high reset, takes priority over X
//     X      in   serial data bit, sampled every rising edge
//     Y      out  detection flag, decoded from the state register only
//
//   Parameter:
//     OVERLAP  1: the trailing 1 of a match may begin the next match
//              0: detection restarts from scratch after each match
//
//   state | meaning
//   ------+---------------------------
//   S0    | nothing matched
//   S1    | "1" matched
//   S2    | "10" matched
//   S3    | "100" matched
//   S4    | "1001" matched, Y high

module sequence_detector #(
  parameter bit OVERLAP = 1'b1
) (
  input  logic Clk,
  input  logic Reset,
  input  logic X,
  output logic Y
);

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } state_t;

  state_t state_q;
  state_t state_d;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S0;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = S0;
    case (state_q)
      S0: state_d = X ? S1 : S0;
      S1: state_d = X ? S1 : S2;
      S2: state_d = X ? S1 : S3;
      S3: state_d = X ? S4 : S0;
      // The final 1 of a match already counts as "1"; with overlap a
      // following 0 therefore leaves us with "10" matched.
      S4: begin
        if (X) begin
          state_d = S1;
        end else begin
          state_d = OVERLAP ? S2 : S0;
        end
      end
      // Unused encodings fall back to idle.
      default: state_d = S0;
    endcase
  end

  // Moore output: no path from X to Y.
  assign Y = (state_q == S4);

endmodule

// File: tb/tb_sequence_detector.sv
// Directed bench for sequence_detector. Two instances run in lockstep on the
// same stimulus, one with overlapping detection and one without. Each
// stimulus step pushes the hand-computed Y of both instances into a
// scoreboard queue after the sampling edge; an independent monitor pops and
// compares on the falling edge.

module tb_sequence_detector;

  logic Clk;
  logic Reset;
  logic X;
  logic y_ov1;
  logic y_ov0;

  typedef struct {
    logic  y1;
    logic  y0;
    string tag;
  } exp_t;

  exp_t sb[$];
  int   n_vec;
  int   n_err;

  sequence_detector #(.OVERLAP(1'b1)) dut_ov1 (
    .Clk  (Clk),
    .Reset(Reset),
    .X    (X),
    .Y    (y_ov1)
  );

  sequence_detector #(.OVERLAP(1'b0)) dut_ov0 (
    .Clk  (Clk),
    .Reset(Reset),
    .X    (X),
    .Y    (y_ov0)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Monitor: Y settles after the rising edge, checked on the falling edge.
  always @(negedge Clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_vec++;
      if (y_ov1 !== e.y1) begin
        n_err++;
        $display("FAIL %s overlap=1: Y=%b expected %b", e.tag, y_ov1, e.y1);
      end
      n_vec++;
      if (y_ov0 !== e.y0) begin
        n_err++;
        $display("FAIL %s overlap=0: Y=%b expected %b", e.tag, y_ov0, e.y0);
      end
    end
  end

  // Apply one bit (and reset level) for one rising edge, then record the
  // Y each instance must show after that edge.
  task automatic step(input logic x, input logic r, input logic e1,
                      input logic e0, input string tag);
    exp_t e;
    @(negedge Clk);
    X     = x;
    Reset = r;
    @(posedge Clk);
    e.y1 = e1;
    e.y0 = e0;
    e.tag = tag;
    sb.push_back(e);
  endtask

  // Stream applied with Reset low where both variants expect the same Y.
  task automatic run_same(input logic [15:0] bits, input logic [15:0] exp,
                          input int len, input string tag);
    for (int i = len - 1; i >= 0; i--) begin
      step(bits[i], 1'b0, exp[i], exp[i], tag);
    end
  endtask

  initial begin
    int wait_cyc;
    n_vec = 0;
    n_err = 0;
    Reset = 1'b1;
    X     = 1'b0;

    // Reset for two cycles, then idle zeros.
    step(1'b0, 1'b1, 1'b0, 1'b0, "reset");
    step(1'b0, 1'b1, 1'b0, 1'b0, "reset");
    run_same(16'b00000, 16'b00000, 5, "idle_zeros");

    // 0,1,0,0,1,1,0,0,1 : pulses after bits 5 and 9.
    run_same(16'b010011001, 16'b000010001, 9, "two_matches");

    // 1,0,0,1,0,0,1 : overlap gives pulses after bits 4 and 7, no overlap
    // only after bit 4 (S4 -0-> S0, then 0,1 only reaches S1).
    step(1'b0, 1'b1, 1'b0, 1'b0, "reset");
    step(1'b1, 1'b0, 1'b0, 1'b0, "overlap_b1");
    step(1'b0, 1'b0, 1'b0, 1'b0, "overlap_b2");
    step(1'b0, 1'b0, 1'b0, 1'b0, "overlap_b3");
    step(1'b1, 1'b0, 1'b1, 1'b1, "overlap_b4");
    step(1'b0, 1'b0, 1'b0, 1'b0, "overlap_b5");
    step(1'b0, 1'b0, 1'b0, 1'b0, "overlap_b6");
    step(1'b1, 1'b0, 1'b1, 1'b0, "overlap_b7");

    // 1,0,0 then reset edge with X=1, then X=1: partial match discarded.
    step(1'b0, 1'b1, 1'b0, 1'b0, "reset");
    run_same(16'b100, 16'b000, 3, "pre_reset");
    step(1'b1, 1'b1, 1'b0, 1'b0, "reset_mid");
    step(1'b1, 1'b0, 1'b0, 1'b0, "post_reset");
    // The post-reset 1 starts a fresh prefix: 0,0,1 completes it.
    run_same(16'b001, 16'b001, 3, "post_reset_match");

    // 1,1,1,0,0,0,1,0,0,1 : S1 self-loop, S3 -> S0 on 1000, one final pulse.
    step(1'b0, 1'b1, 1'b0, 1'b0, "reset");
    run_same(16'b1110001001, 16'b0000000001, 10, "s1_loop_s3_exit");

    // Reset while in S4 clears Y on that edge.
    step(1'b1, 1'b1, 1'b0, 1'b0, "reset_in_s4");
    step(1'b0, 1'b0, 1'b0, 1'b0, "after_reset_s4");

    wait_cyc = 0;
    while (sb.size() > 0 && wait_cyc < 10) begin
      @(posedge Clk);
      wait_cyc++;
    end
    @(posedge Clk);
    if (sb.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
